// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: 160x120 RGB333 framebuffer with a plot write port, scanned out as 640x480@60 VGA in 4x4 blocks.
// Define FB_CLEAR_EN to add the clear engine (clear / clear_busy) that fills the buffer with CLEAR_COLOUR.
module vga_frame_scanout #(
    parameter logic [7:0] FB_W         = 8'd160,
    parameter logic [6:0] FB_H         = 7'd120,
    parameter logic [8:0] CLEAR_COLOUR = 9'h000,
    parameter int         H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
    parameter int         V_VIS = 480, V_FP = 10, V_SYNC = 2, V_BP = 33
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [8:0] colour_in,
    input  logic       plot,
`ifdef FB_CLEAR_EN
    input  logic       clear,
    output logic       clear_busy,
`endif
    output logic       vblank_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);
    localparam int         FB_N   = int'(FB_W) * int'(FB_H);
    localparam logic [9:0] H_V    = 10'(H_VIS);
    localparam logic [9:0] H_SS   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_V    = 10'(V_VIS);
    localparam logic [9:0] V_VL   = 10'(V_VIS - 1);
    localparam logic [9:0] V_SS   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [8:0]  r_mem [FB_N];
    logic        r_pix_en, r_vga_clk, r_vblank;
    logic [9:0]  r_hcnt, r_vcnt;
    logic [14:0] r_addr;
    logic        r_hs1, r_vs1, r_bn1, r_hs2, r_vs2, r_bn2;
    logic [8:0]  r_rd;
    logic        w_vis, w_busy, w_we;
    logic [14:0] w_raddr, w_waddr, w_clr_addr;
    logic [8:0]  w_wdata;

    assign w_vis   = r_hcnt < H_V && r_vcnt < V_V;
    assign w_raddr = 15'(r_vcnt[9:2]) * 15'(FB_W) + 15'(r_hcnt[9:2]);
    assign w_we    = w_busy || (plot && x_in < FB_W && y_in < FB_H);
    assign w_waddr = w_busy ? w_clr_addr : 15'(y_in) * 15'(FB_W) + 15'(x_in);
    assign w_wdata = w_busy ? CLEAR_COLOUR : colour_in;

    // Sync/blank travel two ticks alongside the address and read stages so they line up with the pixel.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_pix_en  <= 1'b0;
            r_vga_clk <= 1'b0;
            r_vblank  <= 1'b0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_addr    <= '0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_bn1     <= 1'b0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_bn2     <= 1'b0;
        end else begin
            r_pix_en  <= ~r_pix_en;
            r_vga_clk <= r_pix_en;
            r_vblank  <= r_pix_en && r_hcnt == H_LAST && r_vcnt == V_VL;
            if (r_pix_en) begin
                r_hcnt <= r_hcnt == H_LAST ? '0 : r_hcnt + 10'd1;
                if (r_hcnt == H_LAST)
                    r_vcnt <= r_vcnt == V_LAST ? '0 : r_vcnt + 10'd1;
                r_addr <= w_vis ? w_raddr : '0;
                r_hs1  <= !(r_hcnt >= H_SS && r_hcnt < H_SE);
                r_vs1  <= !(r_vcnt >= V_SS && r_vcnt < V_SE);
                r_bn1  <= w_vis;
                r_hs2  <= r_hs1;
                r_vs2  <= r_vs1;
                r_bn2  <= r_bn1;
            end
        end
    end

    // Non-blocking read alongside the write gives read-before-write on an address collision.
    always_ff @(posedge clk_50) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (r_pix_en)
            r_rd <= r_mem[r_addr];
    end

`ifdef FB_CLEAR_EN
    logic        r_clr_busy;
    logic [14:0] r_clr_addr;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_clr_busy <= 1'b0;
            r_clr_addr <= '0;
        end else if (!r_clr_busy) begin
            r_clr_busy <= clear;
            r_clr_addr <= 15'(FB_N - 1);
        end else begin
            r_clr_busy <= r_clr_addr != '0;
            r_clr_addr <= r_clr_addr - 15'd1;
        end
    end

    assign clear_busy = r_clr_busy;
    assign w_busy     = r_clr_busy;
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign VGA_R        = r_bn2 ? {r_rd[8:6], r_rd[8:6], r_rd[8:7]} : 8'd0;
    assign VGA_G        = r_bn2 ? {r_rd[5:3], r_rd[5:3], r_rd[5:4]} : 8'd0;
    assign VGA_B        = r_bn2 ? {r_rd[2:0], r_rd[2:0], r_rd[2:1]} : 8'd0;
    assign VGA_HS       = r_hs2;
    assign VGA_VS       = r_vs2;
    assign VGA_BLANK_N  = r_bn2;
    assign VGA_SYNC_N   = 1'b0;
    assign VGA_CLK      = r_vga_clk;
    assign vblank_start = r_vblank;
endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: randomized plot traffic against a positional model of the scanout (short vertical frame).
module tb_vga_frame_scanout;
    localparam int VV = 12, VFP = 2, VSY = 2, VBP = 2;
    localparam int FRAME = 800 * (VV + VFP + VSY + VBP);

    logic       clk_50 = 1'b0, reset = 1'b1, plot = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [8:0] colour_in = '0;
    logic       vblank_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic [7:0] VGA_R, VGA_G, VGA_B;
`ifdef FB_CLEAR_EN
    logic       clear = 1'b0, clear_busy;
`endif
    logic [8:0] fb [19200];
    int         checks = 0, passed = 0;

    always #10 clk_50 = ~clk_50;

    vga_frame_scanout #(.V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
        .clk_50(clk_50), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot(plot),
`ifdef FB_CLEAR_EN
        .clear(clear), .clear_busy(clear_busy),
`endif
        .vblank_start(vblank_start), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
    );

    function automatic logic [7:0] x8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        plot = 1'b0;
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        checks++; if (VGA_HS !== 1'b1) $display("FAIL reset_hs got %b want 1", VGA_HS); else passed++;
        checks++; if (VGA_VS !== 1'b1) $display("FAIL reset_vs got %b want 1", VGA_VS); else passed++;
        checks++; if (VGA_BLANK_N !== 1'b0) $display("FAIL reset_blank_n got %b want 0", VGA_BLANK_N); else passed++;
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb got %h want 0", {VGA_R, VGA_G, VGA_B}); else passed++;
        checks++; if (vblank_start !== 1'b0) $display("FAIL reset_vblank got %b want 0", vblank_start); else passed++;
        checks++; if (VGA_CLK !== 1'b0) $display("FAIL reset_vga_clk got %b want 0", VGA_CLK); else passed++;
        checks++; if (VGA_SYNC_N !== 1'b0) $display("FAIL reset_sync_n got %b want 0", VGA_SYNC_N); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_fill;
        int px [7] = '{0, 159, 159, 160, 170, 5, 255};
        int py [7] = '{0, 0, 119, 1, 0, 120, 127};
        logic [8:0] pc [7] = '{9'h1C0, 9'h007, 9'h007, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 160; x++) begin
                @(negedge clk_50);
                plot = 1'b1; x_in = 8'(x); y_in = 7'(y); colour_in = 9'($urandom);
                fb[y * 160 + x] = colour_in;
            end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_50);
            plot = 1'b1; x_in = 8'(px[i]); y_in = 7'(py[i]); colour_in = pc[i];
            if (px[i] < 160 && py[i] < 120) fb[py[i] * 160 + px[i]] = pc[i];
        end
        @(negedge clk_50);
        plot = 1'b0;
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear;
        int n = 0;
        @(negedge clk_50);
        clear = 1'b1;
        @(negedge clk_50);
        clear = 1'b0;
        while (clear_busy === 1'b1 && n < 20000) begin
            plot = n == 5 || n == 6; x_in = 8'd10; y_in = n == 5 ? 7'd10 : 7'd1; colour_in = 9'h1FF;
            clear = n == 7;
            n++;
            @(negedge clk_50);
        end
        plot = 1'b0;
        clear = 1'b0;
        checks++; if (n !== 19200) $display("FAIL clear_busy_len got %0d want 19200", n); else passed++;
        checks++; if (clear_busy !== 1'b0) $display("FAIL clear_busy_end got %b want 0", clear_busy); else passed++;
        for (int i = 0; i < 19200; i++) fb[i] = 9'h000;
    endtask
`endif

    task automatic test_scanout(input int n, input bit chk);
        int e = 0, k, p, h, v, px = 0, py = 0;
        int hf1 = 0, hf2 = 0, hr = 0, vf1 = 0, vf2 = 0, vr = 0;
        logic ehs = 1'b1, evs = 1'b1, ebn = 1'b0, pw = 1'b0, phs = 1'b1, pvs = 1'b1;
        logic [8:0] epix = '0, pc = '0;
        logic [29:0] want, got;
        @(negedge clk_50);
        reset = 1'b1;
        plot = 1'b0;
        @(negedge clk_50);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
            e++;
            k = e / 2;
            if (e % 2 == 0 && k >= 2) begin
                p = (k - 2) % FRAME; h = p % 800; v = p / 800;
                ehs = !(h >= 656 && h < 752);
                evs = !(v >= VV + VFP && v < VV + VFP + VSY);
                ebn = h < 640 && v < VV;
                epix = ebn ? fb[(v / 4) * 160 + h / 4] : 9'h0;
            end
            want = {ehs, evs, ebn, x8(epix[8:6]), x8(epix[5:3]), x8(epix[2:0]),
                    e % 2 == 0 && k % FRAME == VV * 800, e % 2 == 0, 1'b0};
            got = {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank_start, VGA_CLK, VGA_SYNC_N};
            checks++; if (got !== want) $display("FAIL scan e=%0d got %h want %h", e, got, want); else passed++;
            if (phs && !VGA_HS) begin if (hf1 == 0) hf1 = e; else if (hf2 == 0) hf2 = e; end
            if (!phs && VGA_HS && hf1 != 0 && hr == 0) hr = e;
            if (pvs && !VGA_VS) begin if (vf1 == 0) vf1 = e; else if (vf2 == 0) vf2 = e; end
            if (!pvs && VGA_VS && vf1 != 0 && vr == 0) vr = e;
            phs = VGA_HS;
            pvs = VGA_VS;
            if (pw && px < 160 && py < 120) fb[py * 160 + px] = pc;
            pw = $urandom_range(0, 5) == 0;
            px = $urandom_range(0, 9) == 0 ? $urandom_range(160, 255) : $urandom_range(0, 159);
            py = $urandom_range(0, 19) == 0 ? $urandom_range(120, 127) : $urandom_range(0, 2);
            pc = 9'($urandom);
            plot = pw; x_in = 8'(px); y_in = 7'(py); colour_in = pc;
        end
        plot = 1'b0;
        checks++; if (hf2 - hf1 !== 1600) $display("FAIL hs_period got %0d want 1600", hf2 - hf1); else passed++;
        checks++; if (hr - hf1 !== 192) $display("FAIL hs_low got %0d want 192", hr - hf1); else passed++;
        if (chk) begin
            checks++; if (vf2 - vf1 !== 2 * FRAME) $display("FAIL vs_period got %0d want %0d", vf2 - vf1, 2 * FRAME); else passed++;
            checks++; if (vr - vf1 !== VSY * 1600) $display("FAIL vs_low got %0d want %0d", vr - vf1, VSY * 1600); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_fill;
`ifdef FB_CLEAR_EN
        test_clear;
`endif
        test_scanout(4 * FRAME + 10, 1'b1);
        test_scanout(4000, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
